chk_arbiter: RTL and testbench
==============================

Name: chk_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one XOR-property checker between N_REQ requesters.
- The checker evaluates the immediate-assertion condition (a ^ b) on operands sampled from the granted requester.
- The block accumulates pass/fail statistics and provides a global enable, equivalent to assertion on/off control.
- It sits beside the module-level checkers, clocked by the same clk, and serialises check requests so that only one evaluation is in flight.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- CNT_W, 8, width of the pass/fail counters; counters saturate at 2**CNT_W-1.
- CHK_LAT, 2, cycles spent in EVAL; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global check enable; when 0, no new grant is issued.
- req  input  N_REQ  per-requester request; level, held until that requester's done.
- a  input  N_REQ  per-requester operand a.
- b  input  N_REQ  per-requester operand b.
- gnt  output  N_REQ  one-hot grant; high for exactly the GRANT cycle.
- busy  output  1  high in GRANT, EVAL and REPORT.
- done  output  1  one-cycle pulse in REPORT.
- pass  output  1  result valid with done: 1 = (a^b)==1.
- done_id  output  $clog2(N_REQ)  index of the reported requester, valid with done.
- pass_cnt  output  CNT_W  saturating count of passes.
- fail_cnt  output  CNT_W  saturating count of failures.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, busy=0, done=0, pass=0, done_id=0, pass_cnt=0, fail_cnt=0, rr pointer=0, lat counter=0.
- All outputs are registered.
- IDLE:
  - If en=1 and |req, select the first requester with req=1 scanning from ptr upward (modulo N_REQ).
  - Next cycle: GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - gnt[sel]=1.
  - Sample op = a[sel]^b[sel] into a register at the end of the cycle.
  - Load lat=CHK_LAT-1.
  - Next state: EVAL.
- EVAL (CHK_LAT cycles):
  - lat decrements each cycle.
  - When lat==0, next state is REPORT.
- REPORT (1 cycle):
  - done=1, pass=op, done_id=sel.
  - pass_cnt+1 if op=1, else fail_cnt+1; counters hold at all-ones (saturate, no wrap).
  - ptr=(sel+1) mod N_REQ.
  - Next state: IDLE.
- Latency: req sampled in IDLE at cycle t -> gnt at t+1 -> done at t+CHK_LAT+2.
- Minimum spacing between grants: CHK_LAT+3 cycles.
- en affects only the IDLE->GRANT decision. Dropping en mid-operation does not abort; the in-flight check completes and reports.
- If req[sel] drops after GRANT, the operation still completes and reports. Operands changing after GRANT are ignored.
- A requester must keep req high until its done. If a requester re-asserts immediately after its own done, it has lowest priority on the next arbitration.
- If all N_REQ requesters are continuously requesting, grant order is strictly rotating: sel, sel+1, ...
- Asserting rst_n low mid-operation clears everything immediately. No done is produced for the aborted check, and counters return to 0.
- Invariants:
  - gnt is one-hot or zero.
  - done never coincides with gnt.
  - busy=0 only in IDLE.

Test Plan:
- Reset then idle, en=1, req=0 for 10 cycles -> gnt=0, done=0, busy=0, counters 0.
- Single requester: req=4'b0010, a[1]=1, b[1]=0 at cycle 0 ->
  - gnt=4'b0010 at cycle 1.
  - done=1, pass=1, done_id=1 at cycle 4 (CHK_LAT=2).
  - pass_cnt=1.
- Full contention: req=4'b1111 held, all a^b=0 ->
  - grants in order 0,1,2,3,0 spaced 5 cycles apart.
  - fail_cnt=4 after the fourth done.
  - pass_cnt=0.
- Enable control: en=0 with req=4'b0001 for 20 cycles -> no gnt. Set en=1 -> gnt at the next cycle+1. Drop en during EVAL -> done still pulses.
- Saturation with CNT_W=2: 5 passing checks -> pass_cnt stops at 3 and does not wrap.
- Reset mid-EVAL: assert rst_n=0 during EVAL -> all outputs 0 immediately, no done after release, and the next grant goes to requester 0.

Source files
------------

// File: rtl/chk_arbiter.sv
// Round-robin sequencer sharing one (a ^ b) checker between N_REQ requesters.
// Tracks saturating pass/fail statistics; en gates only new grants.
module chk_arbiter #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 8,
  parameter int CHK_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         a,
  input  logic [N_REQ-1:0]         b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int LW = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    EVAL,
    REPORT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            op_q, op_d;
  logic [N_REQ-1:0] gnt_d;
  logic            busy_d, done_d, pass_d;
  logic [IW-1:0]   done_id_d;
  logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   ptr_nx;

  // First requester at or above ptr, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    pick  = sel_q;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign ptr_nx = (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    lat_d      = lat_q;
    op_d       = op_q;
    gnt_d      = '0;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    done_id_d  = done_id;
    pass_cnt_d = pass_cnt;
    fail_cnt_d = fail_cnt;
    unique case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d      = GRANT;
          sel_d        = pick;
          gnt_d[pick]  = 1'b1;
          busy_d       = 1'b1;
        end
      end
      GRANT: begin
        op_d    = a[sel_q] ^ b[sel_q];
        lat_d   = LW'(CHK_LAT - 1);
        state_d = EVAL;
      end
      EVAL: begin
        if (lat_q == '0) begin
          state_d   = REPORT;
          done_d    = 1'b1;
          pass_d    = op_q;
          done_id_d = sel_q;
          ptr_d     = ptr_nx;
          if (op_q) begin
            if (pass_cnt != '1) pass_cnt_d = pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != '1) fail_cnt_d = fail_cnt + CNT_W'(1);
          end
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      lat_q    <= '0;
      op_q     <= 1'b0;
      gnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      done_id  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      lat_q    <= lat_d;
      op_q     <= op_d;
      gnt      <= gnt_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      done_id  <= done_id_d;
      pass_cnt <= pass_cnt_d;
      fail_cnt <= fail_cnt_d;
    end
  end

endmodule

// File: tb/tb_chk_arbiter.sv
// Directed bench for chk_arbiter: default build plus a CNT_W=2 copy
// sharing the same stimulus for counter saturation.
module tb_chk_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] a;
  logic [3:0] b;

  logic [3:0] gnt;
  logic       busy, done, pass;
  logic [1:0] done_id;
  logic [7:0] pass_cnt, fail_cnt;

  logic [3:0] s_gnt;
  logic       s_busy, s_done, s_pass;
  logic [1:0] s_done_id;
  logic [1:0] s_pass_cnt, s_fail_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chk_arbiter #(.N_REQ(4), .CNT_W(8), .CHK_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .a(a), .b(b),
    .gnt(gnt), .busy(busy), .done(done), .pass(pass),
    .done_id(done_id), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  chk_arbiter #(.N_REQ(4), .CNT_W(2), .CHK_LAT(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .a(a), .b(b),
    .gnt(s_gnt), .busy(s_busy), .done(s_done), .pass(s_pass),
    .done_id(s_done_id), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out", {gnt, busy, done, pass, done_id}, 0);
    chk("rst_cnt", {pass_cnt, fail_cnt}, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    a     = '0;
    b     = '0;
    step();
    do_reset();

    // idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {gnt, busy, done}, 0);
    end
    chk("idle_cnt", {pass_cnt, fail_cnt}, 0);

    // single requester 1, a^b=1
    a   = 4'b0010;
    b   = 4'b0000;
    req = 4'b0010;
    step();
    chk("single_gnt", gnt, 4'b0010);
    chk("single_busy", busy, 1);
    step();
    chk("single_eval", {gnt, done, busy}, 1);
    step();
    chk("single_eval2", done, 0);
    step();
    chk("single_done", {done, pass, done_id}, {1'b1, 1'b1, 2'd1});
    chk("single_gnt0", gnt, 0);
    chk("single_pcnt", pass_cnt, 1);
    req = 4'b0000;
    step();
    chk("single_end", {done, busy}, 0);

    // full contention from reset, all a^b=0
    do_reset();
    a   = 4'b0101;
    b   = 4'b0101;
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr_gnt", gnt, 32'(1 << g));
      step();
      step();
      step();
      chk("rr_done", {done, pass, done_id}, {1'b1, 1'b0, 2'(g)});
      step();
      chk("rr_gap", {gnt, done, busy}, 0);
    end
    chk("rr_fcnt", fail_cnt, 4);
    chk("rr_pcnt", pass_cnt, 0);
    step();
    chk("rr_wrap", gnt, 4'b0001);
    step();
    step();
    step();
    chk("rr_wrap_done", {done, done_id}, {1'b1, 2'd0});
    req = 4'b0000;
    step();
    chk("rr_fcnt5", fail_cnt, 5);

    // enable control
    en  = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("en_off", {gnt, busy}, 0);
    end
    en = 1'b1;
    step();
    chk("en_gnt", gnt, 4'b0001);
    step();
    en = 1'b0;
    step();
    step();
    chk("en_done", {done, done_id}, {1'b1, 2'd0});
    step();
    step();
    chk("en_hold", {gnt, busy}, 0);
    req = 4'b0000;

    // saturation: five passing checks on requester 0
    do_reset();
    en  = 1'b1;
    a   = 4'b1111;
    b   = 4'b0000;
    req = 4'b0001;
    for (int n = 1; n <= 5; n++) begin
      step();
      step();
      step();
      step();
      chk("sat_done", {done, s_done}, 2'b11);
      chk("sat_cnt", s_pass_cnt, (n > 3) ? 3 : n);
      chk("wide_cnt", pass_cnt, n);
      step();
    end
    req = 4'b0000;
    chk("sat_fcnt", {s_fail_cnt, fail_cnt}, 0);

    // reset mid-EVAL
    req = 4'b0100;
    step();
    chk("mid_gnt", gnt, 4'b0100);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {gnt, busy, done, pass, done_id}, 0);
    chk("mid_cnt", {pass_cnt, fail_cnt}, 0);
    step();
    rst_n = 1'b1;
    req   = 4'b0101;
    step();
    chk("post_gnt", gnt, 4'b0001);
    chk("post_nodone", done, 0);
    step();
    step();
    chk("post_nodone2", done, 0);
    step();
    chk("post_done", {done, done_id}, {1'b1, 2'd0});
    req = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
